fifo_wr_ptr_ctrl: RTL and testbench

Write-side pointer controller for the asynchronous FIFO, living entirely in the write clock domain. It qualifies write requests against full and drives the FIFO memory write enable and address. It advances the binary write pointer and publishes a registered Gray-coded write pointer for the read-domain synchronizer. It also derives full, almost-full and fill level from the read pointer, which arrives already synchronized in Gray code.

---
 rtl/fifo_wr_ptr_ctrl.sv | 94 +++++++++
 tb/tb_fifo_wr_ptr_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_ptr_ctrl.sv
// Async FIFO write-side pointer control: qualifies writes, drives memory strobe/address, and publishes Gray pointer, full/almost-full and fill level.
// Latency: wr_en_mem is same-cycle combinational; pointer, flags and count register on the accepting edge. Backpressure: writes are dropped while full.
// Optional WR_OVF_FLAG_EN adds sticky ovf_err, set on a write attempt while full.
module fifo_wr_ptr_ctrl #(
    parameter int ADDR_WIDTH = 3,
    parameter int AF_THRESH  = 7
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH:0]   rd_gray_ptr_sync,
    output logic                  wr_en_mem,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH:0]   wr_gray_ptr,
    output logic                  full,
    output logic                  almost_full,
`ifdef WR_OVF_FLAG_EN
    output logic [ADDR_WIDTH:0]   wr_count,
    output logic                  ovf_err
`else
    output logic [ADDR_WIDTH:0]   wr_count
`endif
);

    localparam int P = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] AF_LVL = AF_THRESH[ADDR_WIDTH:0];

    logic [P-1:0] r_bin;
    logic [P-1:0] r_gray;
    logic         r_full;
    logic         r_af;
    logic [P-1:0] r_count;

    logic         w_accept;
    logic [P-1:0] w_bin_next;
    logic [P-1:0] w_gray_next;
    logic [P-1:0] w_rd_bin;
    logic [P-1:0] w_full_cmp;
    logic [P-1:0] w_count_next;

    assign w_accept    = wr_req & ~r_full & ~RST;
    assign w_bin_next  = r_bin + {{ADDR_WIDTH{1'b0}}, w_accept};
    assign w_gray_next = w_bin_next ^ (w_bin_next >> 1);

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        w_rd_bin = '0;
        for (int i = 0; i < P; i++) begin
            w_rd_bin[i] = ^(rd_gray_ptr_sync >> i);
        end
    end

    // Full when the write pointer is exactly one lap ahead of the read pointer.
    assign w_full_cmp   = {~rd_gray_ptr_sync[P-1:P-2], rd_gray_ptr_sync[P-3:0]};
    assign w_count_next = w_bin_next - w_rd_bin;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_bin   <= '0;
            r_gray  <= '0;
            r_full  <= 1'b0;
            r_af    <= 1'b0;
            r_count <= '0;
        end else begin
            r_bin   <= w_bin_next;
            r_gray  <= w_gray_next;
            r_full  <= (w_gray_next == w_full_cmp);
            r_af    <= (w_count_next >= AF_LVL);
            r_count <= w_count_next;
        end
    end

`ifdef WR_OVF_FLAG_EN
    logic r_ovf;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ovf <= 1'b0;
        end else if (wr_req && r_full) begin
            r_ovf <= 1'b1;
        end
    end

    assign ovf_err = r_ovf;
`endif

    assign wr_en_mem   = w_accept;
    assign wr_addr     = r_bin[ADDR_WIDTH-1:0];
    assign wr_gray_ptr = r_gray;
    assign full        = r_full;
    assign almost_full = r_af;
    assign wr_count    = r_count;

endmodule

// File: tb/tb_fifo_wr_ptr_ctrl.sv
// Directed bench for fifo_wr_ptr_ctrl (ADDR_WIDTH=3, AF_THRESH=7): vector table plus hand sequences.
module tb_fifo_wr_ptr_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       wr_req = 1'b0;
    logic [3:0] rd_gray_ptr_sync = 4'b0000;
    logic       wr_en_mem;
    logic [2:0] wr_addr;
    logic [3:0] wr_gray_ptr;
    logic       full;
    logic       almost_full;
    logic [3:0] wr_count;
`ifdef WR_OVF_FLAG_EN
    logic       ovf_err;
`endif

    fifo_wr_ptr_ctrl #(.ADDR_WIDTH(3), .AF_THRESH(7)) dut (
        .CLK              (CLK),
        .RST              (RST),
        .wr_req           (wr_req),
        .rd_gray_ptr_sync (rd_gray_ptr_sync),
        .wr_en_mem        (wr_en_mem),
        .wr_addr          (wr_addr),
        .wr_gray_ptr      (wr_gray_ptr),
        .full             (full),
        .almost_full      (almost_full),
`ifdef WR_OVF_FLAG_EN
        .wr_count         (wr_count),
        .ovf_err          (ovf_err)
`else
        .wr_count         (wr_count)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       rst;
        logic       req;
        logic [3:0] rd;
        logic       en;
        logic [2:0] addr;
        logic [3:0] gray;
        logic       full;
        logic       af;
        logic [3:0] cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void addv(input logic rst, input logic req, input logic [3:0] rd,
                                 input logic en, input logic [2:0] addr, input logic [3:0] gray,
                                 input logic f, input logic af, input logic [3:0] cnt);
        vec_t v;
        v.rst = rst; v.req = req; v.rd = rd; v.en = en; v.addr = addr;
        v.gray = gray; v.full = f; v.af = af; v.cnt = cnt;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic rst, input logic req, input logic [3:0] rd);
        @(negedge CLK);
        RST = rst;
        wr_req = req;
        rd_gray_ptr_sync = rd;
        #1;
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Eight writes from empty with read pointer at 0.
    task automatic add_fill;
        addv(0, 1, 4'b0000, 1, 3'd0, 4'b0001, 0, 0, 4'd1);
        addv(0, 1, 4'b0000, 1, 3'd1, 4'b0011, 0, 0, 4'd2);
        addv(0, 1, 4'b0000, 1, 3'd2, 4'b0010, 0, 0, 4'd3);
        addv(0, 1, 4'b0000, 1, 3'd3, 4'b0110, 0, 0, 4'd4);
        addv(0, 1, 4'b0000, 1, 3'd4, 4'b0111, 0, 0, 4'd5);
        addv(0, 1, 4'b0000, 1, 3'd5, 4'b0101, 0, 0, 4'd6);
        addv(0, 1, 4'b0000, 1, 3'd6, 4'b0100, 0, 1, 4'd7);
        addv(0, 1, 4'b0000, 1, 3'd7, 4'b1100, 1, 1, 4'd8);
    endtask

    initial begin
        // Reset mid-run: three writes, then RST together with wr_req.
        addv(0, 1, 4'b0000, 1, 3'd0, 4'b0001, 0, 0, 4'd1);
        addv(0, 1, 4'b0000, 1, 3'd1, 4'b0011, 0, 0, 4'd2);
        addv(0, 1, 4'b0000, 1, 3'd2, 4'b0010, 0, 0, 4'd3);
        addv(1, 1, 4'b0000, 0, 3'd3, 4'b0000, 0, 0, 4'd0);
        addv(0, 0, 4'b0000, 0, 3'd0, 4'b0000, 0, 0, 4'd0);
        // Fill from empty, then two blocked requests.
        add_fill();
        addv(0, 1, 4'b0000, 0, 3'd0, 4'b1100, 1, 1, 4'd8);
        addv(0, 1, 4'b0000, 0, 3'd0, 4'b1100, 1, 1, 4'd8);
        // Drain release, then the next write lands at address 0.
        addv(0, 0, 4'b0001, 0, 3'd0, 4'b1100, 0, 1, 4'd7);
        addv(0, 1, 4'b0001, 1, 3'd0, 4'b1101, 1, 1, 4'd8);
        addv(1, 0, 4'b0000, 0, 3'd1, 4'b0000, 0, 0, 4'd0);
        // Wrap: get wr_bin to 8, move read pointer to 8, write eight more.
        add_fill();
        addv(0, 0, 4'b1100, 0, 3'd0, 4'b1100, 0, 0, 4'd0);
        addv(0, 1, 4'b1100, 1, 3'd0, 4'b1101, 0, 0, 4'd1);
        addv(0, 1, 4'b1100, 1, 3'd1, 4'b1111, 0, 0, 4'd2);
        addv(0, 1, 4'b1100, 1, 3'd2, 4'b1110, 0, 0, 4'd3);
        addv(0, 1, 4'b1100, 1, 3'd3, 4'b1010, 0, 0, 4'd4);
        addv(0, 1, 4'b1100, 1, 3'd4, 4'b1011, 0, 0, 4'd5);
        addv(0, 1, 4'b1100, 1, 3'd5, 4'b1001, 0, 0, 4'd6);
        addv(0, 1, 4'b1100, 1, 3'd6, 4'b1000, 0, 1, 4'd7);
        addv(0, 1, 4'b1100, 1, 3'd7, 4'b0000, 1, 1, 4'd8);
        // Read advance while full blocks the write; then read and write together.
        addv(0, 1, 4'b1101, 0, 3'd0, 4'b0000, 0, 1, 4'd7);
        addv(0, 1, 4'b1111, 1, 3'd0, 4'b0001, 0, 1, 4'd7);
        addv(0, 0, 4'b1111, 0, 3'd1, 4'b0001, 0, 1, 4'd7);

        // Initial reset with wr_req high: no strobe, all state cleared.
        drive(1, 1, 4'b0000);
        check("rst_en", wr_en_mem, 0);
        tick();
        drive(1, 1, 4'b0000);
        check("rst_en2", wr_en_mem, 0);
        tick();
        check("rst_gray", wr_gray_ptr, 4'b0000);
        check("rst_full", full, 0);
        check("rst_af", almost_full, 0);
        check("rst_cnt", wr_count, 0);
        check("rst_addr", wr_addr, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].req, vecs[i].rd);
            check($sformatf("v%0d_en", i), wr_en_mem, vecs[i].en);
            check($sformatf("v%0d_addr", i), wr_addr, vecs[i].addr);
            tick();
            check($sformatf("v%0d_gray", i), wr_gray_ptr, vecs[i].gray);
            check($sformatf("v%0d_full", i), full, vecs[i].full);
            check($sformatf("v%0d_af", i), almost_full, vecs[i].af);
            check($sformatf("v%0d_cnt", i), wr_count, vecs[i].cnt);
        end

        // Hand sequence: fill, hold wr_req against full for several cycles.
        drive(1, 0, 4'b0000);
        tick();
        for (int k = 0; k < 8; k++) begin
            drive(0, 1, 4'b0000);
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, 4'b0000);
            check("hold_en", wr_en_mem, 0);
            tick();
            check("hold_gray", wr_gray_ptr, 4'b1100);
            check("hold_addr", wr_addr, 3'd0);
            check("hold_full", full, 1);
        end
`ifdef WR_OVF_FLAG_EN
        check("ovf_set", ovf_err, 1);
        drive(0, 0, 4'b0001);
        tick();
        check("ovf_drain_full", full, 0);
        check("ovf_sticky", ovf_err, 1);
        drive(0, 0, 4'b0001);
        tick();
        check("ovf_sticky2", ovf_err, 1);
        drive(1, 0, 4'b0000);
        tick();
        check("ovf_clr", ovf_err, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
